// File: rtl/gift_pkg.sv
// gift_pkg: shared constants, FSM states and key/constant step functions for the GIFT-128 key schedule
package gift_pkg;
  localparam int KEY_W = 128;
  localparam int RK_W = 136;
  localparam int CONST_W = 6;
  localparam int ROUNDS_DEFAULT = 40;
  localparam logic [CONST_W-1:0] C_INIT = 6'h01;
  typedef enum logic [1:0] {IDLE, PRECOMP, STREAM} state_t;
  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k);
    return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
  endfunction
  function automatic logic [KEY_W-1:0] key_update_inv(input logic [KEY_W-1:0] n);
    return {n[95:0], n[125:112], n[127:126], n[99:96], n[111:100]};
  endfunction
  function automatic logic [CONST_W-1:0] lfsr_fwd(input logic [CONST_W-1:0] c);
    return {c[4:0], c[5] ^ c[4] ^ 1'b1};
  endfunction
  function automatic logic [CONST_W-1:0] lfsr_inv(input logic [CONST_W-1:0] c);
    return {c[0] ^ c[5] ^ 1'b1, c[5:1]};
  endfunction
endpackage

// File: rtl/gift_key_step.sv
// gift_key_step: one forward or inverse step of the key state and round constant
module gift_key_step
  import gift_pkg::*;
(
  input  logic               i_inv,
  input  logic [KEY_W-1:0]   i_key,
  input  logic [CONST_W-1:0] i_const,
  output logic [KEY_W-1:0]   o_key,
  output logic [CONST_W-1:0] o_const
);
  assign o_key = i_inv ? key_update_inv(i_key) : key_update(i_key);
  assign o_const = i_inv ? lfsr_inv(i_const) : lfsr_fwd(i_const);
endmodule

// File: rtl/gift_inv_key_schedule.sv
// gift_inv_key_schedule: precomputes the last round key, then streams round keys backward to round 1
module gift_inv_key_schedule
  import gift_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic             inClk,
  input  logic             inRstN,
  input  logic             inStart,
  input  logic [KEY_W-1:0] inKey,
  input  logic             inKeyReady,
  output logic             outKeyValid,
  output logic [RK_W-1:0]  outRoundKey,
  output logic [5:0]       outRound,
  output logic             outLast,
  output logic             outBusy,
  output logic             outDone
);
  localparam logic [5:0] LAST_PRE = 6'(ROUNDS - 1);
  state_t r_state, w_next;
  logic [KEY_W-1:0] r_key, w_step_key;
  logic [CONST_W-1:0] r_const, w_step_const;
  logic [5:0] r_cnt;
  logic r_done;
  logic w_accept, w_cnt_one;
  assign w_accept = (r_state == STREAM) && inKeyReady;
  assign w_cnt_one = r_cnt == 6'd1;
  gift_key_step u_step (
    .i_inv   (r_state == STREAM),
    .i_key   (r_key),
    .i_const (r_const),
    .o_key   (w_step_key),
    .o_const (w_step_const)
  );
  // state register
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state: precompute until the counter reaches ROUNDS, stream until round 1 is taken
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = inStart ? PRECOMP : IDLE;
      PRECOMP: w_next = (r_cnt == LAST_PRE) ? STREAM : PRECOMP;
      STREAM:  w_next = (w_accept && w_cnt_one) ? IDLE : STREAM;
      default: w_next = IDLE;
    endcase
  end
  // key, constant and round counter; forward while precomputing, inverse on each accepted key
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      r_key <= '0;
      r_const <= '0;
      r_cnt <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_accept && w_cnt_one;
      if (r_state == IDLE && inStart) begin
        r_key <= inKey;
        r_const <= C_INIT;
        r_cnt <= 6'd1;
      end else if (r_state == PRECOMP || (w_accept && !w_cnt_one)) begin
        r_key <= w_step_key;
        r_const <= w_step_const;
        r_cnt <= (r_state == PRECOMP) ? r_cnt + 6'd1 : r_cnt - 6'd1;
      end
    end
  end
  assign outKeyValid = r_state == STREAM;
  assign outRoundKey = {r_key, 2'b00, r_const};
  assign outRound = r_cnt;
  assign outLast = outKeyValid && w_cnt_one;
  assign outBusy = r_state != IDLE;
  assign outDone = r_done;
endmodule

// File: tb/tb_gift_inv_key_schedule.sv
// tb_gift_inv_key_schedule: directed checks of the default and ROUNDS=2 key schedulers
module tb_gift_inv_key_schedule;
  logic inClk = 1'b0;
  logic inRstN = 1'b0;
  logic inStart = 1'b0;
  logic inStart2 = 1'b0;
  logic inKeyReady = 1'b1;
  logic [127:0] inKey = '0;
  logic [127:0] inKey2 = '0;
  logic vA, lA, bA, dA, vB, lB, bB, dB;
  logic [135:0] kA, kB;
  logic [5:0] rA, rB;
  int n_chk = 0;
  int n_err = 0;
  logic [5:0] ctab [1:40] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
                              6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
                              6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
                              6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A};
  logic [127:0] ek [1:40];

  gift_inv_key_schedule u_dut (
    .inClk(inClk), .inRstN(inRstN), .inStart(inStart), .inKey(inKey), .inKeyReady(inKeyReady),
    .outKeyValid(vA), .outRoundKey(kA), .outRound(rA), .outLast(lA), .outBusy(bA), .outDone(dA)
  );
  gift_inv_key_schedule #(.ROUNDS(2)) u_dut2 (
    .inClk(inClk), .inRstN(inRstN), .inStart(inStart2), .inKey(inKey2), .inKeyReady(inKeyReady),
    .outKeyValid(vB), .outRoundKey(kB), .outRound(rB), .outLast(lB), .outBusy(bB), .outDone(dB)
  );

  always #5 inClk = ~inClk;

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fwd(input logic [127:0] k);
    logic [15:0] w0, w1;
    w0 = k[15:0];
    w1 = k[31:16];
    return {(w1 >> 2) | (w1 << 14), (w0 >> 12) | (w0 << 4), k[127:32]};
  endfunction

  task automatic start_a(input logic [127:0] key, input bit pulse);
    int n;
    ek[1] = key;
    for (int r = 2; r <= 40; r++) ek[r] = fwd(ek[r-1]);
    inKey = key;
    inStart = 1'b1;
    @(negedge inClk);
    inStart = 1'b0;
    n = 0;
    while (!vA && n < 100) begin
      if (pulse && n == 10) inStart = 1'b1;
      @(negedge inClk);
      inStart = 1'b0;
      n++;
    end
    chk("latency", n, 39);
  endtask

  task automatic stream_a(input int stall_r, input bit pulse, input int rst_r);
    for (int r = 40; r >= 1; r--) begin
      chk("valid", vA, 1);
      chk("round", rA, r);
      chk("key", kA, {ek[r], 2'b00, ctab[r]});
      chk("last", lA, r == 1);
      if (r == stall_r) begin
        inKeyReady = 1'b0;
        repeat (5) begin
          @(negedge inClk);
          chk("stall key", kA, {ek[r], 2'b00, ctab[r]});
          chk("stall round", rA, r);
        end
        inKeyReady = 1'b1;
      end
      if (r == rst_r) begin
        inRstN = 1'b0;
        #1;
        chk("rst valid", vA, 0);
        chk("rst key", kA, 0);
        chk("rst round", rA, 0);
        chk("rst busy", bA, 0);
        chk("rst last", lA, 0);
        chk("rst done", dA, 0);
        @(negedge inClk);
        inRstN = 1'b1;
        @(negedge inClk);
        return;
      end
      if (pulse && r == 30) inStart = 1'b1;
      @(negedge inClk);
      inStart = 1'b0;
    end
    chk("end valid", vA, 0);
    chk("done pulse", dA, 1);
    chk("end busy", bA, 0);
    @(negedge inClk);
    chk("done low", dA, 0);
  endtask

  task automatic run_b(input logic [127:0] key, input logic [127:0] exp2);
    int n;
    inKey2 = key;
    inStart2 = 1'b1;
    @(negedge inClk);
    inStart2 = 1'b0;
    n = 0;
    while (!vB && n < 20) begin
      @(negedge inClk);
      n++;
    end
    chk("r2 latency", n, 1);
    chk("r2 key2", kB, {exp2, 2'b00, 6'h03});
    chk("r2 round2", rB, 2);
    chk("r2 last2", lB, 0);
    @(negedge inClk);
    chk("r2 key1", kB, {key, 2'b00, 6'h01});
    chk("r2 round1", rB, 1);
    chk("r2 last1", lB, 1);
    @(negedge inClk);
    chk("r2 done", dB, 1);
    chk("r2 valid off", vB, 0);
  endtask

  initial begin
    repeat (2) @(negedge inClk);
    chk("reset valid", vA, 0);
    chk("reset key", kA, 0);
    chk("reset round", rA, 0);
    chk("reset busy", bA, 0);
    chk("reset done", dA, 0);
    chk("reset last", lA, 0);
    inRstN = 1'b1;
    @(negedge inClk);
    start_a('0, 0);
    chk("busy", bA, 1);
    stream_a(0, 0, 0);
    run_b(128'h1, 128'h0000_0010_0000_0000_0000_0000_0000_0000);
    run_b(128'h0000_0000_0000_0000_0000_0000_0001_0000, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    start_a(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0);
    stream_a(37, 0, 0);
    start_a(128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0, 1);
    stream_a(0, 1, 0);
    start_a(128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0, 0);
    stream_a(0, 0, 20);
    start_a(128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0, 0);
    stream_a(0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/gift_inv_key_schedule.md
Name: gift_inv_key_schedule

Overview:
- Sequential round-key supplier sitting directly upstream of the GIFT-128 inverse round function; produces its 136-bit key word one decryption round at a time.
- On start, captures the 128-bit master key and runs the forward key schedule and round-constant LFSR up to round ROUNDS.
- It then streams keys backward (round ROUNDS down to 1) using the inverse key update and inverse LFSR, over a valid/ready handshake.

Parameters:
- ROUNDS, 40, number of cipher rounds streamed; legal range 2..62.

Ports:
- inClk  input  1  clock, rising edge.
- inRstN  input  1  asynchronous, active-low reset.
- inStart  input  1  start request; sampled only in IDLE.
- inKey  input  128  master key K = k7||…||k0 (16-bit words, k7 = bits [127:112]); sampled with inStart.
- inKeyReady  input  1  consumer accepts outRoundKey this cycle.
- outKeyValid  output  1  outRoundKey/outRound valid.
- outRoundKey  output  136  [135:8] = 128-bit key state for the round, [7:6] = 2'b00, [5:0] = 6-bit round constant.
- outRound  output  6  round index of the current key, ROUNDS..1.
- outLast  output  1  high with outKeyValid when outRound == 1.
- outBusy  output  1  high in PRECOMP and STREAM.
- outDone  output  1  one-cycle pulse after the round-1 key is accepted.

Behaviour:
- Reset (async, inRstN = 0): state IDLE; key register, constant register, counter, outRoundKey, and outRound all cleared; outKeyValid, outLast, outBusy, and outDone are all 0.
- Forward update: k7..k0 <- (k1 >>> 2)||(k0 >>> 12)||k7||k6||k5||k4||k3||k2.
- Inverse update: k7..k2 <- n5..n0; k1 <- n7 <<< 2; k0 <- n6 <<< 12.
- Forward LFSR: c <- {c[4:0], c[5]^c[4]^1}. Initial value 6'h01 is round 1.
- Inverse LFSR: c <- {c[0]^c[5]^1, c[5:1]}.
- IDLE:
  - On inStart = 1: load key <- inKey, c <- 6'h01, cnt <- 1, go to PRECOMP.
  - Otherwise hold. outDone is low except for the pulse cycle.
- PRECOMP:
  - One forward update per cycle: key and c advance, cnt++.
  - The transition to STREAM happens on the edge where cnt becomes ROUNDS.
  - Exactly ROUNDS-1 updates are applied. outKeyValid rises ROUNDS-1 cycles after the edge that samples inStart (39 cycles for the default).
  - Incoming inStart is ignored.
- STREAM:
  - outKeyValid = 1 and outRound = cnt.
  - outRoundKey is registered and holds stable while inKeyReady = 0.
  - On accept (valid & ready) with cnt > 1: apply the inverse update and inverse LFSR, cnt--. The next key is valid on the following cycle with no bubble.
  - On accept with cnt == 1: go to IDLE, outKeyValid drops, outDone pulses for 1 cycle.
- Constant sequence streamed for the default: 0x1A, 0x2D, 0x36, …, 0x07, 0x03, 0x01.
- inStart while busy: ignored, with no effect on state or outputs.
- inStart in the same cycle as the outDone pulse: accepted, because the state is already IDLE.
- Reset mid-PRECOMP or mid-STREAM: immediate return to reset values. No partial key is retained.

Decomposition:
- Shared package gift_pkg holds:
  - constants KEY_W = 128, RK_W = 136, CONST_W = 6, C_INIT = 6'h01, ROUNDS_DEFAULT = 40;
  - the FSM state enum (IDLE, PRECOMP, STREAM);
  - functions key_update, key_update_inv, lfsr_fwd, lfsr_inv.
- One natural sub-module: gift_key_step, a combinational forward/inverse step selected by a direction bit, covering both the key state and the constant.

Test Plan:
- Default ROUNDS, inKey = 0, inKeyReady = 1 → outKeyValid rises 39 cycles after inStart. 40 consecutive keys follow, all with [135:8] = 0. Constants are 0x1A, 0x2D, …, 0x01. outRound runs 40..1, outLast on the final key, then a single outDone pulse.
- ROUNDS = 2, inKey = 128'h1 (k0 = 0x0001) → first key [135:8] = 128'h0000_0010_0000_0000_0000_0000_0000_0000 with const 0x03. Second key [135:8] = 128'h1 with const 0x01.
- ROUNDS = 2, inKey with k1 = 0x0001 only → first key [135:8] = 128'h4000_0000_…_0000.
- Backpressure: hold inKeyReady = 0 for 5 cycles at round 37 → outRoundKey and outRound stay stable and nothing advances. Release → round 36 appears on the next cycle.
- inStart pulsed during PRECOMP and during STREAM → ignored. The key sequence is identical to the run without the extra pulses.
- Assert inRstN = 0 at round 20 → all outputs zero immediately. A new inStart after release produces the full correct 40-key sequence.
